// File: rtl/cam_pack_pkg.sv
// Shared constants and types for the camera pixel packer and its word FIFO.
package cam_pack_pkg;

  localparam int PIXEL_WIDTH = 32;
  localparam int DATA_WIDTH  = 2 * PIXEL_WIDTH;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/cam_pack_fifo.sv
// First-word-fall-through FIFO; head entry reads as zero while empty.
module cam_pack_fifo
  import cam_pack_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = fifo_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  entry_t  i_entry,
  input  logic    i_pop,
  output entry_t  o_entry,
  output logic    o_full,
  output logic    o_empty,
  output logic [AW:0] o_count
);

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_entry   = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_entry;
  end

endmodule

// File: rtl/cam_dma_pixel_packer.sv
// Packs a non-stallable 32-bit pixel stream into 64-bit DMA words, buffers them
// and tags frame ends with wlast; tracks completed frames and dropped words.
module cam_dma_pixel_packer
  import cam_pack_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   io_peripheralClk,
  input  logic                   io_peripheralReset,
  input  logic                   i_enable,
  input  logic                   i_pix_valid,
  input  logic [PIXEL_WIDTH-1:0] i_pix_data,
  input  logic                   i_pix_sof,
  input  logic                   i_pix_eof,
  input  logic                   cam_dma_wready,
  output logic                   cam_dma_wvalid,
  output logic                   cam_dma_wlast,
  output logic [DATA_WIDTH-1:0]  cam_dma_wdata,
  output logic [CNT_WIDTH-1:0]   o_frame_cnt,
  output logic [CNT_WIDTH-1:0]   o_drop_cnt,
  output logic                   o_err,
  output logic                   o_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PIXEL_WIDTH-1:0] PIX_ZERO = '0;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_half;
  logic                    w_half_nxt;
  logic                    w_lo_load;
  logic [PIXEL_WIDTH-1:0]  r_lo;
  logic                    w_vld;
  logic                    w_last;
  logic                    w_err;
  logic [DATA_WIDTH-1:0]   w_word;
  logic                    r_vld_p0;
  logic                    r_last_p0;
  logic [DATA_WIDTH-1:0]   r_word_p0;
  logic                    r_err;
  logic [CNT_WIDTH-1:0]    r_frame_cnt;
  logic [CNT_WIDTH-1:0]    r_drop_cnt;
  fifo_entry_t             w_push_entry;
  fifo_entry_t             w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [CW-1:0]           w_count;
  logic                    w_pop;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_drop;

  always_ff @(posedge io_peripheralClk) begin
    if (io_peripheralReset) r_state <= ST_IDLE;
    else                    r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_half_nxt  = r_half;
    w_lo_load   = 1'b0;
    w_vld       = 1'b0;
    w_last      = 1'b0;
    w_err       = 1'b0;
    w_word      = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_pix_valid && i_pix_sof && i_enable) begin
          if (i_pix_eof) begin
            w_vld  = 1'b1;
            w_last = 1'b1;
            w_word = {PIX_ZERO, i_pix_data};
          end else begin
            w_lo_load   = 1'b1;
            w_half_nxt  = 1'b1;
            w_state_nxt = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        if (i_pix_valid) begin
          if (i_pix_sof) begin
            // Truncated frame: close it out, the sof pixel opens the next one.
            w_err      = 1'b1;
            w_vld      = 1'b1;
            w_last     = 1'b1;
            w_word     = r_half ? {PIX_ZERO, r_lo} : '0;
            w_lo_load  = 1'b1;
            w_half_nxt = 1'b1;
          end else if (r_half) begin
            w_vld      = 1'b1;
            w_last     = i_pix_eof;
            w_word     = {i_pix_data, r_lo};
            w_half_nxt = 1'b0;
            if (i_pix_eof) w_state_nxt = ST_IDLE;
          end else if (i_pix_eof) begin
            w_vld       = 1'b1;
            w_last      = 1'b1;
            w_word      = {PIX_ZERO, i_pix_data};
            w_state_nxt = ST_IDLE;
          end else begin
            w_lo_load  = 1'b1;
            w_half_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: packed word registered, pushed into the FIFO next cycle
  always_ff @(posedge io_peripheralClk) begin
    if (io_peripheralReset) begin
      r_half    <= 1'b0;
      r_lo      <= '0;
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_half    <= w_half_nxt;
      if (w_lo_load) r_lo <= i_pix_data;
      r_vld_p0  <= w_vld;
      r_last_p0 <= w_last;
      r_err     <= w_err;
    end
  end

  always_ff @(posedge io_peripheralClk) begin
    if (w_vld) r_word_p0 <= w_word;
  end

  // Top slot is reserved so frame-closing words are never lost.
  assign w_pop    = cam_dma_wvalid && cam_dma_wready;
  assign w_accept = r_last_p0 ? (!w_full || w_pop) : (w_count < CW'(FIFO_DEPTH - 1));
  assign w_push   = r_vld_p0 && w_accept;
  assign w_drop   = r_vld_p0 && !w_accept;

  assign w_push_entry.last = r_last_p0;
  assign w_push_entry.data = r_word_p0;

  cam_pack_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .i_clk   (io_peripheralClk),
    .i_rst   (io_peripheralReset),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_entry (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge io_peripheralClk) begin
    if (io_peripheralReset) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_pop && w_head.last) r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
      if (w_drop)               r_drop_cnt  <= sat_inc(r_drop_cnt);
    end
  end

  assign cam_dma_wvalid = !w_empty;
  assign cam_dma_wlast  = w_head.last;
  assign cam_dma_wdata  = w_head.data;
  assign o_frame_cnt    = r_frame_cnt;
  assign o_drop_cnt     = r_drop_cnt;
  assign o_err          = r_err;
  assign o_busy         = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_cam_dma_pixel_packer.sv
// Directed scoreboard bench for cam_dma_pixel_packer.
module tb_cam_dma_pixel_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pix_valid;
  logic [31:0] pix_data;
  logic        pix_sof;
  logic        pix_eof;
  logic        wready;
  logic        wvalid;
  logic        wlast;
  logic [63:0] wdata;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        err;
  logic        busy;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  cam_dma_pixel_packer #(.FIFO_DEPTH(16), .CNT_WIDTH(16)) dut (
    .io_peripheralClk   (clk),
    .io_peripheralReset (rst),
    .i_enable           (en),
    .i_pix_valid        (pix_valid),
    .i_pix_data         (pix_data),
    .i_pix_sof          (pix_sof),
    .i_pix_eof          (pix_eof),
    .cam_dma_wready     (wready),
    .cam_dma_wvalid     (wvalid),
    .cam_dma_wlast      (wlast),
    .cam_dma_wdata      (wdata),
    .o_frame_cnt        (frame_cnt),
    .o_drop_cnt         (drop_cnt),
    .o_err              (err),
    .o_busy             (busy)
  );

  // Monitor: every accepted DMA word is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && wvalid && wready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word got last=%0b data=%h, expected no word", wlast, wdata);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({wlast, wdata} !== e) begin
          bad++;
          $display("FAIL dma_word got last=%0b data=%h, expected last=%0b data=%h",
                   wlast, wdata, e[64], e[63:0]);
        end
      end
    end
    if (!rst && err) err_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expw(input logic last, input logic [63:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic e);
    pix_valid = v;
    pix_data  = d;
    pix_sof   = s;
    pix_eof   = e;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; wready = 1'b1;
    pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; pix_eof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_wvalid", 64'(wvalid), 64'd0);
    chk("reset_wlast", 64'(wlast), 64'd0);
    chk("reset_wdata", wdata, 64'd0);
    chk("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_err", 64'(err), 64'd0);

    // 8-pixel frame, wready high, latency probe around pixel 2
    expw(1'b0, 64'h0000000200000001);
    expw(1'b0, 64'h0000000400000003);
    expw(1'b0, 64'h0000000600000005);
    expw(1'b1, 64'h0000000800000007);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i + 1), i == 0, i == 7);
      if (i == 1) chk("latency_not_yet", 64'(wvalid), 64'd0);
      if (i == 2) chk("latency_wvalid_2cyc", 64'(wvalid), 64'd1);
    end
    idle(6);
    chk("frame8_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("frame8_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("frame8_busy_idle", 64'(busy), 64'd0);

    // 5-pixel frame, odd count pads upper half
    expw(1'b0, 64'h0000000200000001);
    expw(1'b0, 64'h0000000400000003);
    expw(1'b1, 64'h0000000000000005);
    for (int i = 0; i < 5; i++) drive(1'b1, 32'(i + 1), i == 0, i == 4);
    idle(6);
    chk("frame5_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("frame5_queue_drained", 64'(exp_q.size()), 64'd0);

    // 40-pixel frame with wready low: 15 stored, 4 dropped, eof word kept
    wready = 1'b0;
    for (int j = 0; j < 15; j++)
      expw(1'b0, {32'h100 + 32'(2*j + 1), 32'h100 + 32'(2*j)});
    expw(1'b1, 64'h0000012700000126);
    for (int i = 0; i < 40; i++) drive(1'b1, 32'h100 + 32'(i), i == 0, i == 39);
    idle(4);
    chk("overflow_drop_cnt", 64'(drop_cnt), 64'd4);
    chk("overflow_wvalid_held", 64'(wvalid), 64'd1);
    chk("overflow_head_data", wdata, 64'h0000010100000100);
    chk("overflow_frame_cnt_stalled", 64'(frame_cnt), 64'd2);
    wready = 1'b1;
    idle(20);
    chk("overflow_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("overflow_frame_cnt", 64'(frame_cnt), 64'd3);
    chk("overflow_drop_cnt_final", 64'(drop_cnt), 64'd4);

    // sof after 3 pixels truncates the frame
    expw(1'b0, 64'h0000000200000001);
    expw(1'b1, 64'h0000000000000003);
    expw(1'b0, 64'h0000002200000021);
    expw(1'b1, 64'h0000002400000023);
    drive(1'b1, 32'h1, 1'b1, 1'b0);
    drive(1'b1, 32'h2, 1'b0, 1'b0);
    drive(1'b1, 32'h3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h21 + 32'(i), i == 0, i == 3);
    idle(6);
    chk("trunc_err_pulses", 64'(err_seen), 64'd1);
    chk("trunc_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("trunc_frame_cnt", 64'(frame_cnt), 64'd5);

    // enable low in IDLE: frame ignored
    en = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h51 + 32'(i), i == 0, i == 3);
    idle(5);
    chk("disabled_no_wvalid", 64'(wvalid), 64'd0);
    chk("disabled_busy", 64'(busy), 64'd0);
    chk("disabled_frame_cnt", 64'(frame_cnt), 64'd5);

    // enable dropped mid-frame: frame completes
    en = 1'b1;
    expw(1'b0, 64'h0000003200000031);
    expw(1'b1, 64'h0000003400000033);
    drive(1'b1, 32'h31, 1'b1, 1'b0);
    en = 1'b0;
    drive(1'b1, 32'h32, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    drive(1'b1, 32'h34, 1'b0, 1'b1);
    idle(6);
    chk("en_drop_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("en_drop_frame_cnt", 64'(frame_cnt), 64'd6);

    // reset with 5 words queued
    en = 1'b1;
    wready = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b1, 32'h41 + 32'(i), i == 0, i == 9);
    idle(3);
    chk("prereset_wvalid", 64'(wvalid), 64'd1);
    chk("prereset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_wvalid", 64'(wvalid), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("midreset_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    wready = 1'b1;
    idle(4);
    chk("postreset_no_wvalid", 64'(wvalid), 64'd0);
    chk("postreset_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
